// File: rtl/pll_md_pkg.sv
// pll_md_pkg
//   Definitions shared by both ends of the PLL dynamic-config MD bus.
//   - MD_* opcode encodings carried on mdopc
//   - lock_state_e: state of the modelled PLL lock sequencer
//   - sat_inc8: saturating 8-bit increment used by the commit counter
package pll_md_pkg;

    localparam logic [1:0] MD_NOP     = 2'b00;
    localparam logic [1:0] MD_WRITE   = 2'b01;
    localparam logic [1:0] MD_READ    = 2'b10;
    localparam logic [1:0] MD_SETADDR = 2'b11;

    typedef enum logic {
        LOCK_ACQUIRE = 1'b0,
        LOCK_LOCKED  = 1'b1
    } lock_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_md_responder_if.sv
// pll_md_responder_if
//   MD bus between a PLL_INIT-style initiator (master) and the register-file
//   responder (slave).
//   Handshake: there is no valid/ready pair. The initiator presents one opcode
//   per mdclk edge on mdopc/mdainc/mdwdi and the responder always accepts it
//   (MD_NOP is the idle value). mdrdo is a registered value updated one edge
//   after a READ and held until the next READ.
//   Signals:
//     mdopc      initiator -> responder  opcode (MD_NOP/WRITE/READ/SETADDR)
//     mdainc     initiator -> responder  post-increment pointer on WRITE/READ
//     mdwdi      initiator -> responder  write data, or new pointer on SETADDR
//     mdrdo      responder -> initiator  read data
//     lock       responder -> initiator  modelled PLL lock
//     commit_cnt responder -> initiator  accepted commits, saturating
//     lock_state responder -> observer   lock sequencer state (debug)
interface pll_md_responder_if;
    import pll_md_pkg::*;

    logic [1:0]  mdopc;
    logic        mdainc;
    logic [7:0]  mdwdi;
    logic [7:0]  mdrdo;
    logic        lock;
    logic [7:0]  commit_cnt;
    lock_state_e lock_state;

    modport master (
        output mdopc, mdainc, mdwdi,
        input  mdrdo, lock, commit_cnt, lock_state
    );

    modport slave (
        input  mdopc, mdainc, mdwdi,
        output mdrdo, lock, commit_cnt, lock_state
    );

endinterface

// File: rtl/pll_md_lock_seq.sv
// pll_md_lock_seq
//   Two-state lock model. ACQUIRE counts mdclk edges; once the counter has
//   reached LOCK_CYCLES-1 the next state is LOCKED, which holds until restart
//   or reset. Restart (a commit) returns to ACQUIRE with counter 0, so every
//   acquisition takes a full LOCK_CYCLES edges measured from the restart edge.
//   Ports:
//     mdclk    in   clock
//     reset    in   synchronous active-high reset (same effect as restart)
//     restart  in   begin a new acquisition
//     lock     out  1 while LOCKED
//     state    out  current FSM state (debug)
module pll_md_lock_seq
    import pll_md_pkg::*;
#(
    parameter int LOCK_CYCLES = 64
) (
    input  logic        mdclk,
    input  logic        reset,
    input  logic        restart,
    output logic        lock,
    output lock_state_e state
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q <= LOCK_ACQUIRE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (restart) begin
            // Restart wins over the ACQUIRE->LOCKED transition in the same edge.
            state_d = LOCK_ACQUIRE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOCK_ACQUIRE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = LOCK_LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LOCK_LOCKED: begin
                    state_d = LOCK_LOCKED;
                end
                default: begin
                    state_d = LOCK_ACQUIRE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign lock  = (state_q == LOCK_LOCKED);
    assign state = state_q;

endmodule

// File: rtl/pll_md_responder.sv
// pll_md_responder
//   Responder end of the PLL dynamic-config MD bus: a byte register file with
//   an auto-incrementing pointer, a read-only identity byte, a commit register
//   that restarts lock acquisition, and a lock model.
//   Ports:
//     mdclk  in     clock for all logic
//     reset  in     synchronous active-high reset; beats any opcode that edge
//     md     slave  MD bus (opcode/data in, mdrdo/lock/commit_cnt out)
//   ADDR_W must not exceed 8 since SETADDR loads the pointer from mdwdi.
module pll_md_responder
    import pll_md_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter logic [7:0]        INIT_VALUE  = 8'h00,
    parameter logic [ADDR_W-1:0] ID_ADDR     = '0,
    parameter logic [7:0]        ID_VALUE    = 8'hA5,
    parameter logic [ADDR_W-1:0] COMMIT_ADDR = '1,
    parameter int                LOCK_CYCLES = 64
) (
    input  logic               mdclk,
    input  logic               reset,
    pll_md_responder_if.slave  md
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        rdo_q, rdo_d;
    logic [7:0]        commit_cnt_q, commit_cnt_d;
    logic              wr_en;
    logic              commit;
    logic              lock;
    lock_state_e       lock_state;

    // Opcode decode. Pointer arithmetic wraps naturally at ADDR_W bits.
    always_comb begin
        ptr_d        = ptr_q;
        rdo_d        = rdo_q;
        commit_cnt_d = commit_cnt_q;
        wr_en        = 1'b0;
        commit       = 1'b0;
        case (md.mdopc)
            MD_WRITE: begin
                // The identity byte is read-only; writes to it vanish.
                wr_en  = (ptr_q != ID_ADDR);
                commit = (ptr_q == COMMIT_ADDR) && md.mdwdi[0];
                if (md.mdainc) ptr_d = ptr_q + 1'b1;
            end
            MD_READ: begin
                // Data comes from the pre-increment pointer.
                rdo_d = (ptr_q == ID_ADDR) ? ID_VALUE : mem_q[ptr_q];
                if (md.mdainc) ptr_d = ptr_q + 1'b1;
            end
            MD_SETADDR: begin
                ptr_d = md.mdwdi[ADDR_W-1:0];
            end
            default: begin
            end
        endcase
        if (commit) commit_cnt_d = sat_inc8(commit_cnt_q);
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            ptr_q        <= '0;
            rdo_q        <= 8'h00;
            commit_cnt_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VALUE;
            end
        end else begin
            ptr_q        <= ptr_d;
            rdo_q        <= rdo_d;
            commit_cnt_q <= commit_cnt_d;
            if (wr_en) mem_q[ptr_q] <= md.mdwdi;
        end
    end

    pll_md_lock_seq #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_seq (
        .mdclk   (mdclk),
        .reset   (reset),
        .restart (commit),
        .lock    (lock),
        .state   (lock_state)
    );

    assign md.mdrdo      = rdo_q;
    assign md.lock       = lock;
    assign md.commit_cnt = commit_cnt_q;
    assign md.lock_state = lock_state;

endmodule

// File: tb/tb_pll_md_responder.sv
module tb_pll_md_responder;
    import pll_md_pkg::*;

    localparam int         LOCK_CYCLES = 64;
    localparam logic [7:0] INIT_VALUE  = 8'h00;
    localparam logic [7:0] ID_ADDR     = 8'h00;
    localparam logic [7:0] ID_VALUE    = 8'hA5;
    localparam logic [7:0] COMMIT_ADDR = 8'hFF;

    // ---------------- clock / reset ----------------
    logic mdclk = 1'b0;
    logic reset = 1'b1;
    always #5 mdclk = ~mdclk;

    pll_md_responder_if md();

    pll_md_responder #(
        .ADDR_W      (8),
        .INIT_VALUE  (INIT_VALUE),
        .ID_ADDR     (ID_ADDR),
        .ID_VALUE    (ID_VALUE),
        .COMMIT_ADDR (COMMIT_ADDR),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .mdclk (mdclk),
        .reset (reset),
        .md    (md)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // since_m counts edges after the start of the current acquisition
    // (reset edge or commit edge); lock is expected once it reaches LOCK_CYCLES.
    logic [7:0] mem_m [256];
    logic [7:0] ptr_m, rdo_m, commit_m;
    int         since_m;

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = INIT_VALUE;
        ptr_m    = 8'h00;
        rdo_m    = 8'h00;
        commit_m = 8'h00;
        since_m  = 0;
    endfunction

    function automatic void model_apply(input logic [1:0] op, input logic inc, input logic [7:0] wdi);
        if (since_m < 100000) since_m++;
        if (op == MD_WRITE) begin
            if (ptr_m != ID_ADDR) mem_m[ptr_m] = wdi;
            if (ptr_m == COMMIT_ADDR && wdi[0]) begin
                if (commit_m != 8'hFF) commit_m = commit_m + 8'd1;
                since_m = 0;
            end
            if (inc) ptr_m = ptr_m + 8'd1;
        end else if (op == MD_READ) begin
            rdo_m = (ptr_m == ID_ADDR) ? ID_VALUE : mem_m[ptr_m];
            if (inc) ptr_m = ptr_m + 8'd1;
        end else if (op == MD_SETADDR) begin
            ptr_m = wdi;
        end
    endfunction

    function automatic logic lock_m();
        return (since_m >= LOCK_CYCLES);
    endfunction

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step(input logic rst, input logic [1:0] op, input logic inc, input logic [7:0] wdi);
        reset     = rst;
        md.mdopc  = op;
        md.mdainc = inc;
        md.mdwdi  = wdi;
        @(posedge mdclk);
        if (rst) model_reset();
        else     model_apply(op, inc, wdi);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, MD_NOP, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1'b1, MD_WRITE, 1'b1, 8'h5A);
        step(1'b1, MD_READ, 1'b0, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'h00) begin n_fail++; $display("FAIL reset_mdrdo: got %h want 00", md.mdrdo); end
        n_checks++;
        if (md.lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", md.lock); end
        n_checks++;
        if (md.commit_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_commit: got %h want 00", md.commit_cnt); end
        n_checks++;
        if (md.lock_state !== LOCK_ACQUIRE) begin n_fail++; $display("FAIL reset_state: got %0d want ACQUIRE", md.lock_state); end
        for (int i = 1; i <= LOCK_CYCLES; i++) begin
            step(1'b0, MD_NOP, 1'b1, 8'h00);
            n_checks++;
            if (md.lock !== lock_m()) begin
                n_fail++; $display("FAIL reset_lock_timing edge %0d: got %b want %b", i, md.lock, lock_m());
            end
        end
        n_checks++;
        if (md.lock !== 1'b1) begin n_fail++; $display("FAIL lock_at_64: got %b want 1", md.lock); end
        n_checks++;
        if (md.mdrdo !== 8'h00) begin n_fail++; $display("FAIL idle_mdrdo: got %h want 00", md.mdrdo); end
    endtask

    task automatic test_write_read();
        step(1'b0, MD_SETADDR, 1'b1, 8'h12);
        step(1'b0, MD_WRITE, 1'b0, 8'h5A);
        step(1'b0, MD_SETADDR, 1'b0, 8'h10);
        step(1'b0, MD_WRITE, 1'b1, 8'h3C);
        step(1'b0, MD_WRITE, 1'b0, 8'hC3);
        step(1'b0, MD_SETADDR, 1'b0, 8'h10);
        n_checks++;
        if (md.mdrdo !== 8'h00) begin n_fail++; $display("FAIL rd_hold_before: got %h want 00", md.mdrdo); end
        step(1'b0, MD_READ, 1'b1, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'h3C) begin n_fail++; $display("FAIL rd_first: got %h want 3C", md.mdrdo); end
        step(1'b0, MD_READ, 1'b1, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'hC3) begin n_fail++; $display("FAIL rd_second: got %h want C3", md.mdrdo); end
        nops(3);
        n_checks++;
        if (md.mdrdo !== 8'hC3) begin n_fail++; $display("FAIL rd_hold: got %h want C3", md.mdrdo); end
        step(1'b0, MD_READ, 1'b0, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'h5A) begin n_fail++; $display("FAIL ptr_after_inc: got %h want 5A", md.mdrdo); end
        // Read right after write to the same byte.
        step(1'b0, MD_WRITE, 1'b0, 8'h96);
        step(1'b0, MD_READ, 1'b0, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'h96) begin n_fail++; $display("FAIL raw_hazard: got %h want 96", md.mdrdo); end
    endtask

    task automatic test_wrap_and_id();
        step(1'b0, MD_SETADDR, 1'b0, 8'hFE);
        step(1'b0, MD_WRITE, 1'b1, 8'h11);
        step(1'b0, MD_WRITE, 1'b1, 8'h00);
        step(1'b0, MD_READ, 1'b0, 8'h00);
        n_checks++;
        if (md.mdrdo !== ID_VALUE) begin n_fail++; $display("FAIL wrap_id_read: got %h want %h", md.mdrdo, ID_VALUE); end
        step(1'b0, MD_WRITE, 1'b0, 8'h77);
        step(1'b0, MD_READ, 1'b0, 8'h00);
        n_checks++;
        if (md.mdrdo !== ID_VALUE) begin n_fail++; $display("FAIL id_readonly: got %h want %h", md.mdrdo, ID_VALUE); end
        step(1'b0, MD_SETADDR, 1'b0, 8'hFE);
        step(1'b0, MD_READ, 1'b1, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'h11) begin n_fail++; $display("FAIL byte_fe: got %h want 11", md.mdrdo); end
        step(1'b0, MD_READ, 1'b1, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'h00) begin n_fail++; $display("FAIL byte_ff: got %h want 00", md.mdrdo); end
        n_checks++;
        if (md.commit_cnt !== commit_m || md.lock !== lock_m()) begin
            n_fail++; $display("FAIL commit_bit0_zero: cnt=%h lock=%b want cnt=%h lock=%b",
                               md.commit_cnt, md.lock, commit_m, lock_m());
        end
    endtask

    task automatic test_commit();
        n_checks++;
        if (md.lock !== 1'b1) begin n_fail++; $display("FAIL pre_commit_lock: got %b want 1", md.lock); end
        step(1'b0, MD_SETADDR, 1'b0, COMMIT_ADDR);
        step(1'b0, MD_WRITE, 1'b0, 8'h01);
        n_checks++;
        if (md.lock !== 1'b0) begin n_fail++; $display("FAIL commit_lock_drop: got %b want 0", md.lock); end
        n_checks++;
        if (md.commit_cnt !== 8'h01) begin n_fail++; $display("FAIL commit_cnt1: got %h want 01", md.commit_cnt); end
        nops(30);
        step(1'b0, MD_WRITE, 1'b0, 8'h01);
        n_checks++;
        if (md.commit_cnt !== 8'h02) begin n_fail++; $display("FAIL commit_cnt2: got %h want 02", md.commit_cnt); end
        for (int i = 1; i <= LOCK_CYCLES; i++) begin
            nops(1);
            n_checks++;
            if (md.lock !== lock_m()) begin
                n_fail++; $display("FAIL recommit_timing edge %0d: got %b want %b", i, md.lock, lock_m());
            end
        end
        n_checks++;
        if (md.lock !== 1'b1) begin n_fail++; $display("FAIL recommit_locked: got %b want 1", md.lock); end
    endtask

    task automatic test_commit_zero();
        step(1'b0, MD_WRITE, 1'b0, 8'h00);
        n_checks++;
        if (md.lock !== 1'b1) begin n_fail++; $display("FAIL zero_commit_lock: got %b want 1", md.lock); end
        n_checks++;
        if (md.commit_cnt !== 8'h02) begin n_fail++; $display("FAIL zero_commit_cnt: got %h want 02", md.commit_cnt); end
        step(1'b0, MD_READ, 1'b0, 8'h00);
        n_checks++;
        if (md.mdrdo !== 8'h00) begin n_fail++; $display("FAIL zero_commit_read: got %h want 00", md.mdrdo); end
    endtask

    task automatic test_reset_midway();
        step(1'b0, MD_SETADDR, 1'b0, 8'h20);
        step(1'b0, MD_WRITE, 1'b0, 8'h99);
        step(1'b0, MD_SETADDR, 1'b0, COMMIT_ADDR);
        step(1'b0, MD_WRITE, 1'b0, 8'h01);
        nops(10);
        step(1'b0, MD_SETADDR, 1'b0, 8'h21);
        step(1'b1, MD_WRITE, 1'b0, 8'h66);
        n_checks++;
        if (md.commit_cnt !== 8'h00 || md.lock !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: cnt=%h lock=%b want 00/0", md.commit_cnt, md.lock);
        end
        step(1'b0, MD_SETADDR, 1'b0, 8'h20);
        step(1'b0, MD_READ, 1'b1, 8'h00);
        n_checks++;
        if (md.mdrdo !== INIT_VALUE) begin n_fail++; $display("FAIL midreset_byte20: got %h want %h", md.mdrdo, INIT_VALUE); end
        step(1'b0, MD_READ, 1'b0, 8'h00);
        n_checks++;
        if (md.mdrdo !== INIT_VALUE) begin n_fail++; $display("FAIL midreset_dropped_write: got %h want %h", md.mdrdo, INIT_VALUE); end
        for (int i = 4; i <= LOCK_CYCLES; i++) begin
            nops(1);
            n_checks++;
            if (md.lock !== lock_m()) begin
                n_fail++; $display("FAIL midreset_lock_timing edge %0d: got %b want %b", i, md.lock, lock_m());
            end
        end
    endtask

    task automatic test_commit_saturate();
        step(1'b0, MD_SETADDR, 1'b0, COMMIT_ADDR);
        for (int i = 0; i < 260; i++) begin
            step(1'b0, MD_WRITE, 1'b0, 8'($urandom) | 8'h01);
            if (i == 253) begin
                n_checks++;
                if (md.commit_cnt !== commit_m) begin n_fail++; $display("FAIL sat_pre: got %h want %h", md.commit_cnt, commit_m); end
            end
        end
        n_checks++;
        if (md.commit_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_hold: got %h want FF", md.commit_cnt); end
        n_checks++;
        if (md.lock !== 1'b0) begin n_fail++; $display("FAIL sat_lock: got %b want 0", md.lock); end
    endtask

    task automatic test_random();
        logic [7:0]  addrs [6];
        logic [1:0]  op;
        logic [7:0]  wdi;
        logic        rst;
        lock_state_e exp_state;
        addrs[0] = 8'h00; addrs[1] = 8'h01; addrs[2] = 8'h10;
        addrs[3] = 8'hFE; addrs[4] = 8'hFF; addrs[5] = 8'h80;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            op  = 2'($urandom_range(0, 3));
            wdi = 8'($urandom);
            if (op == MD_SETADDR && $urandom_range(0, 3) != 0) wdi = addrs[$urandom_range(0, 5)];
            // Keep commits rare enough that LOCKED is reached regularly.
            if (op == MD_WRITE && $urandom_range(0, 15) != 0) wdi[0] = 1'b0;
            if ($urandom_range(0, 99) == 0) begin
                nops(LOCK_CYCLES);
            end
            step(rst, op, 1'($urandom_range(0, 1)), wdi);
            exp_state = lock_m() ? LOCK_LOCKED : LOCK_ACQUIRE;
            n_checks++;
            if (md.mdrdo !== rdo_m || md.lock !== lock_m() || md.commit_cnt !== commit_m || md.lock_state !== exp_state) begin
                n_fail++;
                $display("FAIL random step %0d: rdo=%h lock=%b cnt=%h st=%0d want rdo=%h lock=%b cnt=%h st=%0d",
                         i, md.mdrdo, md.lock, md.commit_cnt, md.lock_state, rdo_m, lock_m(), commit_m, exp_state);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        md.mdopc  = MD_NOP;
        md.mdainc = 1'b0;
        md.mdwdi  = 8'h00;
        model_reset();
        test_reset();
        test_write_read();
        test_wrap_and_id();
        test_commit();
        test_commit_zero();
        test_reset_midway();
        test_commit_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
